dataram_lsu_ctrl: RTL and testbench
===================================

Name: dataram_lsu_ctrl

Overview:
- Load/store sequencer between the core's memory stage and the single-port, word-wide data RAM.
- The RAM performs either a write or a registered read per cycle, has no byte enables, and holds its read register during writes.
- This block converts RISC-V byte, halfword and word loads/stores into RAM cycles: registered reads, direct word writes, and read-modify-write for sub-word stores.
- It provides a valid/ready request port and a single-cycle response pulse.

Parameters:
- WORD, 32, data width (fixed at 32 for RV32 lane logic).
- ADDR, 32, byte-address width of req_addr and width of ram_addr.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RISC-V funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- req_addr  in  ADDR  byte address.
- req_wdata  in  WORD  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  WORD  load result, extended; 0 for stores.
- rsp_err  out  1  misaligned-access flag; valid with rsp_valid.
- ram_addr  out  ADDR  word index = captured req_addr >> 2.
- ram_write  out  1  RAM write strobe.
- ram_din  out  WORD  RAM write data.
- ram_dout  in  WORD  RAM registered read data.

Behaviour:
- States: IDLE, ISSUE, MERGE, LDATA, RESP. A request is accepted on req_valid & req_ready.
- req_ready=1 only in IDLE.
- Capture on acceptance: addr, we, funct3, wdata.
- ram_addr is driven from the captured address and stays stable through the transaction.
- ISSUE:
  - Word store: ram_write=1, ram_din=wdata, next state RESP.
  - Load: ram_write=0, next state LDATA.
  - Sub-word store: ram_write=0 (read for merge), next state MERGE.
- MERGE:
  - The old word is on ram_dout.
  - ram_write=1, ram_din = old word with the target lane replaced.
  - Byte lane = addr[1:0], value wdata[7:0].
  - Halfword lane = addr[1], value wdata[15:0].
  - Little-endian. Next state RESP.
- LDATA:
  - Select lane from ram_dout.
  - Extension: b sign-extends bit 7; h sign-extends bit 15; bu/hu zero-extend; w is the full word.
  - Register the result into rsp_rdata. Next state RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure.
- Latency, counted from acceptance cycle T:
  - Load: rsp_valid at T+3.
  - Word store: rsp_valid at T+2.
  - Sub-word store: rsp_valid at T+3.
  - Next acceptance is possible one cycle after RESP.
- funct3 011, 110, 111 are treated as word access. funct3 bit 2 is ignored for stores.
- ram_write is 0 in every state other than ISSUE (word store) and MERGE.
- ram_dout is never sampled in a cycle following a write.
- Reset:
  - Next state IDLE. rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_addr=0, ram_din=0, captured registers=0.
  - ram_write is gated by rst, so no RAM write occurs in any reset cycle.
  - An in-flight transaction is abandoned with no response. A sub-word store reset in MERGE leaves RAM unmodified.
- Back-to-back requests are not pipelined. req_valid while busy is ignored until IDLE.

Optional Feature:
- Macro: DATARAM_MISALIGN_TRAP_EN.
- Defined:
  - Halfword with addr[0]=1, or word with addr[1:0]!=0, is misaligned.
  - A misaligned request goes IDLE -> RESP directly (rsp_valid at T+1) with rsp_err=1 and rsp_rdata=0.
  - No RAM write is issued.
- Not defined:
  - rsp_err is tied 0.
  - Low address bits below the access size are ignored: halfword uses addr[1]; word uses addr[ADDR-1:2].

Test Plan:
- Store word 0xDEADBEEF to 0x10, then load word 0x10 -> ram_addr=4, ram_write pulse at T+1, rsp_valid at T+2; the load returns 0xDEADBEEF at T+3.
- With word 0x11223344 at addr 0x20: sb 0xAA to 0x21, then lw 0x20 -> RMW read then write of 0x1122AA44; the load returns 0x1122AA44.
- With 0x8000_7F80 at 0x30: lb 0x30 -> 0xFFFFFF80; lbu 0x30 -> 0x00000080; lh 0x32 -> 0xFFFF8000; lhu 0x32 -> 0x00008000.
- sh 0xBEEF to 0x32 over 0x11223344 -> written word 0xBEEF3344, rsp_valid at T+3.
- Assert rst during MERGE of sb to 0x40 holding 0x55555555 -> no ram_write in the reset cycle, no rsp_valid; a subsequent lw 0x40 returns 0x55555555.
- With DATARAM_MISALIGN_TRAP_EN defined, lw 0x13 -> rsp_valid at T+1, rsp_err=1, rsp_rdata=0, ram_write never asserted. Without the macro, the same load reads word index 4.

Source files
------------

// File: rtl/dataram_lsu_ctrl.sv
// Load/store sequencer between the memory stage and a single-port word RAM.
// Optional misaligned-access trap enabled by defining DATARAM_MISALIGN_TRAP_EN.
module dataram_lsu_ctrl #(
  parameter int WORD = 32,
  parameter int ADDR = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [ADDR-1:0] req_addr,
  input  logic [WORD-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [WORD-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic [ADDR-1:0] ram_addr,
  output logic            ram_write,
  output logic [WORD-1:0] ram_din,
  input  logic [WORD-1:0] ram_dout
);

  // Request handshake: a request transfers on the rising edge where
  // req_valid and req_ready are both high; req_ready is high only when idle.
  typedef enum logic [2:0] {IDLE, ISSUE, MERGE, LDATA, RESP} state_t;

  state_t          state;
  logic [ADDR-1:0] addr_q;
  logic            we_q;
  logic [2:0]      funct3_q;
  logic [WORD-1:0] wdata_q;

  logic            cap_byte;
  logic            cap_half;
  logic            cap_word;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [WORD-1:0] load_val;
  logic [WORD-1:0] merged;
  logic            req_misalign;

  // funct3[1:0] alone picks the size; 011/110/111 fall through to word.
  assign cap_byte = (funct3_q[1:0] == 2'b00);
  assign cap_half = (funct3_q[1:0] == 2'b01);
  assign cap_word = funct3_q[1];

  assign req_ready = (state == IDLE);
  assign ram_addr  = {2'b00, addr_q[ADDR-1:2]};

  always_comb begin
    byte_sel = ram_dout[{addr_q[1:0], 3'b000} +: 8];
    half_sel = ram_dout[{addr_q[1], 4'b0000} +: 16];
    load_val = ram_dout;
    if (cap_byte) begin
      load_val = funct3_q[2] ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
    end else if (cap_half) begin
      load_val = funct3_q[2] ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
    end
  end

  always_comb begin
    merged = ram_dout;
    if (cap_byte) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else if (cap_half) begin
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end else begin
      merged = wdata_q;
    end
  end

  // Reset gates the strobe so an interrupted read-modify-write never lands.
  always_comb begin
    ram_write = 1'b0;
    if (!rst) begin
      ram_write = ((state == ISSUE) && we_q && cap_word) || (state == MERGE);
    end
    ram_din = '0;
    if (ram_write) begin
      ram_din = (state == MERGE) ? merged : wdata_q;
    end
  end

`ifdef DATARAM_MISALIGN_TRAP_EN
  logic rsp_err_q;

  always_comb begin
    req_misalign = 1'b0;
    if (req_funct3[1]) begin
      req_misalign = (req_addr[1:0] != 2'b00);
    end else if (req_funct3[0]) begin
      req_misalign = req_addr[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_err_q <= 1'b0;
    end else if (state == IDLE && req_valid) begin
      rsp_err_q <= req_misalign;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign req_misalign = 1'b0;
  assign rsp_err      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      funct3_q  <= 3'b000;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            we_q      <= req_we;
            funct3_q  <= req_funct3;
            wdata_q   <= req_wdata;
            rsp_rdata <= '0;
            if (req_misalign) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (we_q && cap_word) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else if (we_q) begin
            state <= MERGE;
          end else begin
            state <= LDATA;
          end
        end
        MERGE: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
        end
        LDATA: begin
          rsp_rdata <= load_val;
          state     <= RESP;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dataram_lsu_ctrl.sv
// Bench for dataram_lsu_ctrl: behavioural word RAM, directed cases, random traffic
// against an array-based reference memory with byte-lane arithmetic.
module tb_dataram_lsu_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] ram_addr;
  logic        ram_write;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic [31:0] exp_q [$];

  int n_tests;
  int n_fail;

  dataram_lsu_ctrl #(.WORD(32), .ADDR(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .ram_addr   (ram_addr),
    .ram_write  (ram_write),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  // Single-port RAM: write or registered read; read register holds on writes.
  always @(posedge clk) begin
    if (ram_write) mem[ram_addr[5:0]] <= ram_din;
    else           ram_dout <= mem[ram_addr[5:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [31:0] a);
`ifdef DATARAM_MISALIGN_TRAP_EN
    if (f3[1]) return (a % 4) != 0;
    if (f3[0]) return (a % 2) != 0;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  // Driver + reference model for one transaction.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
    int          idx, nbytes, sh, k, rsp_k, wr_cnt, wr_k, exp_lat, exp_wr_k, exp_wr_cnt;
    logic [31:0] old_w, mask, v, new_w, exp_rd, exp_err;
    logic        mis;
    idx    = a / 4;
    nbytes = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    sh     = (nbytes == 1) ? 8 * (a % 4) : (nbytes == 2) ? 16 * ((a / 2) % 2) : 0;
    mask   = (nbytes == 1) ? 32'hFF : (nbytes == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
    old_w  = ref_mem[idx];
    mis    = is_misaligned(f3, a);
    new_w  = old_w;
    exp_rd = 0;
    exp_err = {31'd0, mis};
    if (mis) begin
      exp_lat = 1; exp_wr_cnt = 0; exp_wr_k = 0;
    end else if (we) begin
      new_w = (old_w & ~(mask << sh)) | ((wd & mask) << sh);
      exp_lat = (nbytes == 4) ? 2 : 3;
      exp_wr_cnt = 1;
      exp_wr_k = (nbytes == 4) ? 1 : 2;
    end else begin
      v = (old_w >> sh) & mask;
      if (!f3[2] && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~mask;
      exp_rd = v;
      exp_lat = 3; exp_wr_cnt = 0; exp_wr_k = 0;
    end
    exp_q.push_back(exp_rd);

    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    rsp_k = 0; wr_cnt = 0; wr_k = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_valid  = 1'b0;
        req_we     = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom_range(0, 7));
        req_addr   = $urandom;
        req_wdata  = $urandom;
      end
      check("ram_addr", ram_addr, a / 4);
      if (ram_write) begin
        wr_cnt++;
        wr_k = c;
        check("ram_din", ram_din, new_w);
      end
      if (rsp_valid) begin
        rsp_k = c;
        break;
      end
      check("busy_not_ready", {31'd0, req_ready}, 32'd0);
    end
    check("rsp_latency", rsp_k, exp_lat);
    check("rsp_rdata", rsp_rdata, exp_q.pop_front());
    check("rsp_err", {31'd0, rsp_err}, exp_err);
    check("write_count", wr_cnt, exp_wr_cnt);
    if (exp_wr_cnt != 0) check("write_cycle", wr_k, exp_wr_k);
    ref_mem[idx] = new_w;
    @(negedge clk);
    check("rsp_pulse_end", {31'd0, rsp_valid}, 32'd0);
    check("ready_after_rsp", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_ram_addr", ram_addr, 32'd0);
    check("rst_ram_write", {31'd0, ram_write}, 32'd0);
    check("rst_ram_din", ram_din, 32'd0);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Directed: word store/load, RMW byte, sign/zero extension, halfword store
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    do_req(1'b0, 3'b010, 32'h10, 32'h0);
    check("lw_deadbeef", ref_mem[4], 32'hDEADBEEF);
    do_req(1'b1, 3'b010, 32'h20, 32'h11223344);
    do_req(1'b1, 3'b000, 32'h21, 32'h000000AA);
    do_req(1'b0, 3'b010, 32'h20, 32'h0);
    check("sb_merge_mem", mem[8], 32'h1122AA44);
    do_req(1'b1, 3'b010, 32'h30, 32'h80007F80);
    do_req(1'b0, 3'b000, 32'h30, 32'h0);
    do_req(1'b0, 3'b100, 32'h30, 32'h0);
    do_req(1'b0, 3'b001, 32'h32, 32'h0);
    do_req(1'b0, 3'b101, 32'h32, 32'h0);
    do_req(1'b1, 3'b010, 32'h34, 32'h11223344);
    do_req(1'b1, 3'b001, 32'h36, 32'h0000BEEF);
    check("sh_merge_mem", mem[13], 32'hBEEF3344);
    do_req(1'b0, 3'b010, 32'h13, 32'h0);
    do_req(1'b0, 3'b111, 32'h14, 32'h0);
    do_req(1'b1, 3'b101, 32'h17, 32'h12345678);

    // Reset while a byte store sits in its merge cycle
    do_req(1'b1, 3'b010, 32'h40, 32'h55555555);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h40; req_wdata = 32'h000000AA;
    @(negedge clk);
    req_valid = 1'b0;
    check("rmw_read_no_write", {31'd0, ram_write}, 32'd0);
    @(negedge clk);
    check("merge_write_pending", {31'd0, ram_write}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_gates_write", {31'd0, ram_write}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("no_rsp_after_rst", {31'd0, rsp_valid}, 32'd0);
      check("no_write_after_rst", {31'd0, ram_write}, 32'd0);
      @(negedge clk);
    end
    check("rst_mem_intact", mem[16], 32'h55555555);
    do_req(1'b0, 3'b010, 32'h40, 32'h0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             32'($urandom_range(0, 255)), $urandom);
    end
    for (int i = 0; i < 64; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
